// File: rtl/vc_plane_scheduler.sv
// vc_plane_scheduler
// Time-slices one switch between VC planes. A granted plane drives the switch
// combinationally while ACTIVE; a single GAP cycle separates consecutive
// grants. Planes are chosen round-robin; a plane that is mid-packet on any
// port keeps the switch until the packet is finished.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   data_out_portVC     per-plane per-port flits            [VC][PORTS][DATA_WIDTH]
//   valid_out_portVC    per-plane per-port flit valid       [VC][PORTS]
//   ready_out_portVC    per-plane per-port ready (output)   [VC][PORTS]
//   PortReservedVC      per-plane per-port mid-packet flag  [VC][PORTS]
//   data_in_switch      flits to the switch (output)        [PORTS][DATA_WIDTH]
//   valid_in_switch     flit valid to the switch (output)   [PORTS]
//   ready_in_switch     switch ready                        [PORTS]
//   PortReserved        reservation of the granted plane    [PORTS]
//   VCPlaneSelector     index of the granted plane          [$clog2(VC)]
//   plane_active        high while a plane holds the switch
//
// state  | meaning
// IDLE   | no plane requesting, switch idle
// ACTIVE | VCPlaneSelector plane drives the switch
// GAP    | one dead cycle between planes, next winner chosen here
module vc_plane_scheduler #(
    parameter int VC         = 4,
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SLICE      = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VC-1:0][PORTS-1:0][DATA_WIDTH-1:0] data_out_portVC,
    input  logic [VC-1:0][PORTS-1:0]               valid_out_portVC,
    output logic [VC-1:0][PORTS-1:0]               ready_out_portVC,
    input  logic [VC-1:0][PORTS-1:0]               PortReservedVC,
    output logic [PORTS-1:0][DATA_WIDTH-1:0]       data_in_switch,
    output logic [PORTS-1:0]                       valid_in_switch,
    input  logic [PORTS-1:0]                       ready_in_switch,
    output logic [PORTS-1:0]                       PortReserved,
    output logic [$clog2(VC)-1:0]                  VCPlaneSelector,
    output logic                                   plane_active
);

    localparam int SEL_W = $clog2(VC);
    localparam int CNT_W = $clog2(SLICE + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t           state, stateNext;
    logic [VC-1:0]    req;
    logic             anyReq;
    logic [SEL_W-1:0] lastGrant;
    logic [SEL_W-1:0] winner;
    logic             rrFound;
    int               rrIdx;
    logic             grant;
    logic             selReq;
    logic             selReserved;
    logic             otherReq;
    logic             sliceExpired;
    logic [CNT_W-1:0] sliceCnt;

    always_comb begin
        for (int v = 0; v < VC; v++) begin
            req[v] = (|valid_out_portVC[v]) | (|PortReservedVC[v]);
        end
    end

    assign anyReq = |req;

    // Scan lastGrant+1 .. lastGrant (mod VC); works for any VC, not only 2^n.
    always_comb begin
        winner  = lastGrant;
        rrFound = 1'b0;
        rrIdx   = 0;
        for (int i = 1; i <= VC; i++) begin
            rrIdx = (int'(lastGrant) + i) % VC;
            if (!rrFound && req[rrIdx]) begin
                winner  = SEL_W'(rrIdx);
                rrFound = 1'b1;
            end
        end
    end

    assign selReq      = req[VCPlaneSelector];
    assign selReserved = |PortReservedVC[VCPlaneSelector];
    assign otherReq    = |(req & ~(VC'(1) << VCPlaneSelector));

    // sliceCnt holds the ACTIVE cycles already completed, so the current
    // cycle is the last of the slice once it reaches SLICE-1. This gives a
    // plane exactly SLICE ACTIVE cycles before yielding.
    assign sliceExpired = (sliceCnt >= CNT_W'(SLICE - 1));

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (anyReq) begin
                    grant     = 1'b1;
                    stateNext = ACTIVE;
                end else begin
                    stateNext = IDLE;
                end
            end
            ACTIVE: begin
                if (!selReserved && (!selReq || (sliceExpired && otherReq))) begin
                    stateNext = GAP;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            VCPlaneSelector <= '0;
            lastGrant       <= SEL_W'(VC - 1);
            sliceCnt        <= '0;
        end else begin
            state <= stateNext;
            if (grant) begin
                VCPlaneSelector <= winner;
                lastGrant       <= winner;
                sliceCnt        <= '0;
            end else if (state == ACTIVE && sliceCnt != CNT_W'(SLICE)) begin
                sliceCnt <= sliceCnt + CNT_W'(1);
            end
        end
    end

    // Outputs decode from the state register only, so an asserted reset
    // forces them to zero without a clock edge.
    always_comb begin
        data_in_switch   = '0;
        valid_in_switch  = '0;
        PortReserved     = '0;
        ready_out_portVC = '0;
        plane_active     = 1'b0;
        if (state == ACTIVE) begin
            plane_active                      = 1'b1;
            data_in_switch                    = data_out_portVC[VCPlaneSelector];
            valid_in_switch                   = valid_out_portVC[VCPlaneSelector];
            PortReserved                      = PortReservedVC[VCPlaneSelector];
            ready_out_portVC[VCPlaneSelector] = ready_in_switch;
        end
    end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Self-checking bench for vc_plane_scheduler.
// dutA: VC=4, PORTS=4, SLICE=4. dutB: VC=3, PORTS=4, SLICE=4.
// Inputs change just after a falling edge; outputs are sampled 1 ns later.
module tb_vc_plane_scheduler;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][3:0][DW-1:0] aData;
    logic [3:0][3:0]         aValid, aResv, aReadyOut;
    logic [3:0][DW-1:0]      aDataSw;
    logic [3:0]              aValidSw, aReadySw, aPortRes;
    logic [1:0]              aSel;
    logic                    aActive;

    logic [2:0][3:0][DW-1:0] bData;
    logic [2:0][3:0]         bValid, bResv, bReadyOut;
    logic [3:0][DW-1:0]      bDataSw;
    logic [3:0]              bValidSw, bReadySw, bPortRes;
    logic [1:0]              bSel;
    logic                    bActive;

    vc_plane_scheduler #(.VC(4), .PORTS(4), .DATA_WIDTH(DW), .SLICE(4)) dutA (
        .clk(clk), .rst(rst),
        .data_out_portVC(aData), .valid_out_portVC(aValid),
        .ready_out_portVC(aReadyOut), .PortReservedVC(aResv),
        .data_in_switch(aDataSw), .valid_in_switch(aValidSw),
        .ready_in_switch(aReadySw), .PortReserved(aPortRes),
        .VCPlaneSelector(aSel), .plane_active(aActive));

    vc_plane_scheduler #(.VC(3), .PORTS(4), .DATA_WIDTH(DW), .SLICE(4)) dutB (
        .clk(clk), .rst(rst),
        .data_out_portVC(bData), .valid_out_portVC(bValid),
        .ready_out_portVC(bReadyOut), .PortReservedVC(bResv),
        .data_in_switch(bDataSw), .valid_in_switch(bValidSw),
        .ready_in_switch(bReadySw), .PortReserved(bPortRes),
        .VCPlaneSelector(bSel), .plane_active(bActive));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] valid;
        logic [15:0] resv;
        logic [3:0]  rdy;
        logic        act;
        logic [1:0]  sel;
        logic [3:0]  vsw;
        logic [15:0] rout;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [DW-1:0] pat(input int v, input int p);
        return DW'(16'hA000 | (v << 4) | p);
    endfunction

    function automatic logic [63:0] expData(input logic act, input int sel);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            if (act) r[p*DW +: DW] = pat(sel, p);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic driveA(input logic [15:0] v, input logic [15:0] r, input logic [3:0] rdy);
        aValid   = v;
        aResv    = r;
        aReadySw = rdy;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic doReset();
        driveA(16'h0, 16'h0, 4'h0);
        bValid = '0; bResv = '0; bReadySw = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chkA(input string tag, input logic act, input logic [1:0] sel,
                        input logic [3:0] vsw, input logic [15:0] rout);
        chk({tag, ".active"}, 64'(aActive), 64'(act));
        chk({tag, ".sel"},    64'(aSel),    64'(sel));
        chk({tag, ".vsw"},    64'(aValidSw), 64'(vsw));
        chk({tag, ".rout"},   64'(aReadyOut), 64'(rout));
        chk({tag, ".data"},   64'(aDataSw), expData(act, int'(sel)));
    endtask

    initial begin
        for (int v = 0; v < 4; v++)
            for (int p = 0; p < 4; p++) aData[v][p] = pat(v, p);
        for (int v = 0; v < 3; v++)
            for (int p = 0; p < 4; p++) bData[v][p] = pat(v, p);

        // Alternation of planes 0 and 1, SLICE=4, with partial switch ready.
        tbl[0]  = '{16'h0021, 16'h0, 4'hF, 1'b0, 2'd0, 4'h0, 16'h0000};
        tbl[1]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd0, 4'h1, 16'h000F};
        tbl[2]  = '{16'h0021, 16'h0, 4'h5, 1'b1, 2'd0, 4'h1, 16'h0005};
        tbl[3]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd0, 4'h1, 16'h000F};
        tbl[4]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd0, 4'h1, 16'h000F};
        tbl[5]  = '{16'h0021, 16'h0, 4'hF, 1'b0, 2'd0, 4'h0, 16'h0000};
        tbl[6]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd1, 4'h2, 16'h00F0};
        tbl[7]  = '{16'h0021, 16'h0, 4'h3, 1'b1, 2'd1, 4'h2, 16'h0030};
        tbl[8]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd1, 4'h2, 16'h00F0};
        tbl[9]  = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd1, 4'h2, 16'h00F0};
        tbl[10] = '{16'h0021, 16'h0, 4'hF, 1'b0, 2'd1, 4'h0, 16'h0000};
        tbl[11] = '{16'h0021, 16'h0, 4'hF, 1'b1, 2'd0, 4'h1, 16'h000F};

        // Reset holds outputs low even with requests present.
        driveA(16'h0020, 16'h0, 4'hF);
        bValid = '0; bResv = '0; bReadySw = '0;
        #3;
        chkA("rst0", 1'b0, 2'd0, 4'h0, 16'h0000);
        chk("rst0.pres", 64'(aPortRes), 64'h0);
        doReset();

        // Plane 2 request on port 0: one-cycle grant latency, ready follows switch.
        step(); driveA(16'h0100, 16'h0, 4'h1); #1;
        chkA("p2.idle", 1'b0, 2'd0, 4'h0, 16'h0000);
        step(); #1;
        chkA("p2.act", 1'b1, 2'd2, 4'h1, 16'h0100);
        step(); aReadySw = 4'h0; #1;
        chkA("p2.nordy", 1'b1, 2'd2, 4'h1, 16'h0000);

        // Asynchronous reset mid-ACTIVE, then plane 0 must win over plane 3.
        #2 rst = 1'b0;
        #1;
        chkA("arst", 1'b0, 2'd0, 4'h0, 16'h0000);
        chk("arst.pres", 64'(aPortRes), 64'h0);
        driveA(16'h0, 16'h0, 4'h0);
        step(); rst = 1'b1;
        step(); driveA(16'h1001, 16'h0, 4'hF); #1;
        chkA("arst.idle", 1'b0, 2'd0, 4'h0, 16'h0000);
        step(); #1;
        chkA("arst.first", 1'b1, 2'd0, 4'h1, 16'h000F);

        // Table-driven alternation.
        doReset();
        for (int i = 0; i < 12; i++) begin
            step();
            driveA(tbl[i].valid, tbl[i].resv, tbl[i].rdy);
            #1;
            chkA($sformatf("tbl%0d", i), tbl[i].act, tbl[i].sel, tbl[i].vsw, tbl[i].rout);
        end

        // Reservation on plane 0 blocks slice expiry; plane 3 waits.
        doReset();
        step(); driveA(16'h1000, 16'h0002, 4'hF); #1;
        chk("resv.idle", 64'(aActive), 64'h0);
        for (int c = 1; c <= 9; c++) begin
            step(); #1;
            chk($sformatf("resv.c%0d.active", c), 64'(aActive), 64'h1);
            chk($sformatf("resv.c%0d.sel", c), 64'(aSel), 64'h0);
            chk($sformatf("resv.c%0d.pres", c), 64'(aPortRes), 64'h2);
        end
        step(); driveA(16'h1000, 16'h0000, 4'hF); #1;
        chk("resv.clr.active", 64'(aActive), 64'h1);
        chk("resv.clr.pres", 64'(aPortRes), 64'h0);
        step(); #1;
        chkA("resv.gap", 1'b0, 2'd0, 4'h0, 16'h0000);
        step(); #1;
        chkA("resv.p3", 1'b1, 2'd3, 4'h1, 16'hF000);

        // Plane 1 alone: no gaps past slice expiry; drop -> GAP -> IDLE.
        doReset();
        step(); driveA(16'h0020, 16'h0, 4'hF); #1;
        chk("solo.idle", 64'(aActive), 64'h0);
        for (int c = 1; c <= 20; c++) begin
            step(); #1;
            chk($sformatf("solo.c%0d.active", c), 64'(aActive), 64'h1);
            chk($sformatf("solo.c%0d.sel", c), 64'(aSel), 64'h1);
        end
        step(); driveA(16'h0, 16'h0, 4'hF); #1;
        chkA("solo.drop", 1'b1, 2'd1, 4'h0, 16'h00F0);
        step(); #1;
        chkA("solo.gap", 1'b0, 2'd1, 4'h0, 16'h0000);
        step(); #1;
        chkA("solo.idle2", 1'b0, 2'd1, 4'h0, 16'h0000);

        // VC=3 wrap-around: grant order 0,1,2,0 with one GAP between slices.
        doReset();
        for (int c = 0; c <= 16; c++) begin
            logic expAct;
            step();
            bValid = 12'h111; bResv = '0; bReadySw = 4'hF;
            #1;
            expAct = (c >= 1) && (((c - 1) % 5) != 4);
            chk($sformatf("wrap.c%0d.active", c), 64'(bActive), 64'(expAct));
            if (expAct) begin
                chk($sformatf("wrap.c%0d.sel", c), 64'(bSel), 64'(((c - 1) / 5) % 3));
                chk($sformatf("wrap.c%0d.data", c), 64'(bDataSw), expData(1'b1, ((c - 1) / 5) % 3));
            end else begin
                chk($sformatf("wrap.c%0d.rout", c), 64'(bReadyOut), 64'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_plane_scheduler.md
VC_PLANE_SCHEDULER -- requirements
Module: vc_plane_scheduler

Interface
REQ-001 SHALL have parameter VC, default 4, number of VC planes (>=2, any value, not only powers of two).
REQ-002 SHALL have parameter PORTS, default 4, switch ports per plane.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, flit width.
REQ-004 SHALL have parameter SLICE, default 8, cycles a plane may hold the switch while another plane waits (>=1).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port data_out_portVC, input, VC x PORTS x DATA_WIDTH, per-plane per-port flits.
REQ-008 SHALL have port valid_out_portVC, input, VC x PORTS, per-plane per-port flit valid.
REQ-009 SHALL have port ready_out_portVC, output, VC x PORTS, per-plane per-port ready.
REQ-010 SHALL have port PortReservedVC, input, VC x PORTS, port of that plane is mid-packet.
REQ-011 SHALL have port data_in_switch, output, PORTS x DATA_WIDTH, flits to the switch.
REQ-012 SHALL have port valid_in_switch, output, PORTS, flit valid to the switch.
REQ-013 SHALL have port ready_in_switch, input, PORTS, switch ready.
REQ-014 SHALL have port PortReserved, output, PORTS, reservation of the granted plane.
REQ-015 SHALL have port VCPlaneSelector, output, $clog2(VC), index of the granted plane.
REQ-016 SHALL have port plane_active, output, 1 bit, high when a plane holds the switch.

Function
REQ-017 SHALL compute req[v] = (OR of valid_out_portVC[v]) | (OR of PortReservedVC[v]).
REQ-018 SHALL implement FSM states IDLE, ACTIVE and GAP; plane_active SHALL be 1 only in ACTIVE.
REQ-019 IDLE: when any req bit is set, SHALL latch the round-robin winner into VCPlaneSelector and enter ACTIVE next cycle (1-cycle grant latency).
REQ-020 Round-robin winner SHALL be the first requesting plane scanning last_grant+1, last_grant+2, ... modulo VC, wrapping to last_grant; last_grant SHALL update on every grant.
REQ-021 ACTIVE: data_in_switch, valid_in_switch and PortReserved SHALL equal the selected plane's inputs (combinational, zero latency); ready_out_portVC[sel] SHALL equal ready_in_switch; all other planes' ready SHALL be 0.
REQ-022 A flit SHALL transfer only on a cycle in ACTIVE where valid and ready are both high on that port.
REQ-023 slice_cnt SHALL clear on entry to ACTIVE, increment each ACTIVE cycle, and saturate at SLICE.
REQ-024 ACTIVE SHALL move to GAP when PortReservedVC[sel] is all-zero AND (req[sel]==0 OR (slice_cnt==SLICE AND any other plane requests)).
REQ-025 While any PortReservedVC[sel] bit is set, ACTIVE SHALL NOT be left, regardless of slice_cnt.
REQ-026 With only the selected plane requesting, ACTIVE SHALL persist past slice expiry with no gap.
REQ-027 GAP SHALL last exactly one cycle with valid_in_switch, PortReserved and all ready_out_portVC at 0; it SHALL then select the round-robin winner and enter ACTIVE, or enter IDLE if req is all-zero.
REQ-028 Outside ACTIVE, data_in_switch SHALL be 0 and VCPlaneSelector SHALL hold its last value.
REQ-029 If req changes in the same cycle as a state change, the decision SHALL use the req sampled in that cycle.

Reset
REQ-030 On rst low, the block SHALL immediately, without waiting for clk, set state IDLE, VCPlaneSelector 0, last_grant VC-1 (so plane 0 wins first), slice_cnt 0, plane_active 0, and all valid, ready, data and PortReserved outputs to 0.
REQ-031 If reset asserts mid-packet, no in-flight flit SHALL count as transferred; after release the block SHALL restart from IDLE.

Verification
REQ-032 Reset release, plane 2 valid on port 0 -> 1 cycle later plane_active=1, VCPlaneSelector=2, ready_out_portVC[2][0] follows ready_in_switch[0], other planes' ready = 0.
REQ-033 SLICE=4, planes 0 and 1 streaming, no reservations -> plane 0 ACTIVE for 4 cycles, 1 GAP cycle, then plane 1 for 4 cycles, alternating.
REQ-034 Plane 0 PortReservedVC[0][1]=1 for 10 cycles, plane 3 requesting, SLICE=4 -> no switch until the reservation clears, then GAP, then VCPlaneSelector=3.
REQ-035 VC=3, all planes requesting, last_grant=2 -> grant order 0,1,2,0 (wrap-around).
REQ-036 Plane 1 alone streams 20 cycles, SLICE=4 -> no GAP cycles; when req[1] drops, one GAP cycle, then IDLE with plane_active=0.
REQ-037 rst asserted mid-ACTIVE -> all outputs 0 asynchronously; first grant after release goes to plane 0 if it requests.
